// File: rtl/lfsr_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_burst_ctrl_pkg
//  Brief    : Shared constants and state encodings for the LFSR burst sequencer.
//  Revision : 1.0
// ============================================================================
package lfsr_burst_ctrl_pkg;

    localparam int c_LFSR_W   = 17;
    // Recurrence a[n+17] = a[n] ^ a[n+3] (x^17 + x^3 + 1, maximal length)
    localparam int c_LFSR_TAP = 3;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_GAP    = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/lfsr_burst_ctrl_lfsr17_shift.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr17_shift
//  Brief    : 17-bit Fibonacci LFSR emitting DATA_BITS sequence bits per shift.
//  Revision : 1.0
// ============================================================================
module lfsr17_shift
    import lfsr_burst_ctrl_pkg::*;
#(
    parameter int                  DATA_BITS = 32,
    parameter logic [c_LFSR_W-1:0] SEED      = 17'h15555
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_init,
    input  logic [c_LFSR_W-1:0]  i_seed,
    input  logic                 i_shift,
    output logic [DATA_BITS-1:0] o_data
);

    logic [c_LFSR_W-1:0]           r_state;
    logic [DATA_BITS+c_LFSR_W-1:0] w_ext;

    // Bit 0 of the window is the oldest sequence bit; the top 17 bits are the
    // register contents after DATA_BITS single-bit steps.
    function automatic logic [DATA_BITS+c_LFSR_W-1:0] f_expand(input logic [c_LFSR_W-1:0] s);
        logic [DATA_BITS+c_LFSR_W-1:0] e;
        e = '0;
        e[c_LFSR_W-1:0] = s;
        for (int i = c_LFSR_W; i < DATA_BITS + c_LFSR_W; i++) begin
            e[i] = e[i-c_LFSR_W] ^ e[i-c_LFSR_W+c_LFSR_TAP];
        end
        return e;
    endfunction

    assign w_ext  = f_expand(r_state);
    assign o_data = w_ext[DATA_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_init) begin
            r_state <= i_seed;
        end else if (i_shift) begin
            r_state <= w_ext[DATA_BITS+c_LFSR_W-1:DATA_BITS];
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_burst_ctrl
//  Brief    : Command-driven burst sequencer streaming LFSR words with TLAST.
//  Revision : 1.0
// ============================================================================
module lfsr_burst_ctrl
    import lfsr_burst_ctrl_pkg::*;
#(
    parameter int                  DataBits  = 32,
    parameter int                  LenBits   = 16,
    parameter int                  GapCycles = 0,
    parameter logic [c_LFSR_W-1:0] LfsrSeed  = 17'h15555
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [c_LFSR_W-1:0] cmd_seed,
    input  logic [LenBits-1:0]  cmd_len,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DataBits-1:0] out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                done_abort,
    output logic [LenBits-1:0]  word_count
);

    localparam int                 c_GAP_W    = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((GapCycles > 0) ? GapCycles - 1 : 0);
    localparam logic [LenBits-1:0] c_ONE      = LenBits'(1);

    logic [1:0]         r_state;
    logic [LenBits-1:0] r_remaining;
    logic [LenBits-1:0] r_word_count;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_abort_pend;
    logic               r_done_abort;

    logic w_init;
    logic w_hs;
    logic w_last;

    assign w_init = (r_state == c_ST_IDLE) && cmd_valid;
    assign w_hs   = (r_state == c_ST_STREAM) && out_ready;
    assign w_last = (r_remaining == c_ONE);

    assign cmd_ready  = (r_state == c_ST_IDLE);
    assign busy       = (r_state != c_ST_IDLE);
    assign out_valid  = (r_state == c_ST_STREAM);
    assign out_last   = out_valid && w_last;
    assign done       = (r_state == c_ST_DONE);
    assign done_abort = r_done_abort;
    assign word_count = r_word_count;

    lfsr17_shift #(
        .DATA_BITS (DataBits),
        .SEED      (LfsrSeed)
    ) u_lfsr (
        .clk     (clk),
        .rst     (1'b0),
        .i_init  (w_init),
        .i_seed  (cmd_seed),
        .i_shift (w_hs),
        .o_data  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_remaining  <= '0;
            r_word_count <= '0;
            r_gap_cnt    <= '0;
            r_abort_pend <= 1'b0;
            r_done_abort <= 1'b0;
        end else begin
            r_done_abort <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_remaining  <= cmd_len;
                        r_word_count <= '0;
                        r_abort_pend <= 1'b0;
                        r_state      <= (cmd_len == '0) ? c_ST_DONE : c_ST_STREAM;
                    end
                end
                c_ST_STREAM: begin
                    if (out_ready) begin
                        r_remaining  <= r_remaining - c_ONE;
                        r_word_count <= r_word_count + c_ONE;
                        // Completing the final word wins over any abort request.
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                        end else if (r_abort_pend || abort) begin
                            r_state      <= c_ST_DONE;
                            r_done_abort <= 1'b1;
                        end else if (GapCycles > 0) begin
                            r_state   <= c_ST_GAP;
                            r_gap_cnt <= c_GAP_LOAD;
                        end
                    end else if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (abort) begin
                        r_state      <= c_ST_DONE;
                        r_done_abort <= 1'b1;
                    end else if (r_gap_cnt == '0) begin
                        r_state <= c_ST_STREAM;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_abort_pend <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
